// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : i2c_bus_arbiter                                           |
// | Brief    : Shares one i2c_master between NUM_REQ requesters using    |
// |            round-robin arbitration. Latches the winner's fields,     |
// |            pulses the master reset to start, waits for stop, then    |
// |            returns read data and a one-cycle done pulse.             |
// |            Optional BUSY timeout: define I2C_ARB_TIMEOUT_EN.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module i2c_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int GUARD_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [7*NUM_REQ-1:0]  req_dev_addr,
  input  logic [8*NUM_REQ-1:0]  req_mem_addr,
  input  logic [64*NUM_REQ-1:0] req_data,
  input  logic [4*NUM_REQ-1:0]  req_size,
  input  logic [NUM_REQ-1:0]    req_rw,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic [63:0]           rd_data,
  output logic                  err,
  output logic                  m_rst,
  output logic [6:0]            m_dev_addr,
  output logic [7:0]            m_mem_addr,
  output logic [63:0]           m_data,
  output logic [3:0]            m_size,
  output logic                  m_rw,
  input  logic                  m_stop,
  input  logic [63:0]           m_rd_data
);

  localparam int c_iw      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_cnt_max = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int c_cw      = $clog2(c_cnt_max + 1);

  localparam logic [c_cw-1:0] c_guard   = c_cw'(GUARD_CYCLES);
  localparam logic [c_cw-1:0] c_cnt_sat = {c_cw{1'b1}};

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_load  = 3'd1;
  localparam logic [2:0] c_st_start = 3'd2;
  localparam logic [2:0] c_st_busy  = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [c_iw-1:0]    r_ptr;
  logic [c_iw-1:0]    r_win;
  logic [c_cw-1:0]    r_cnt;
  logic [NUM_REQ-1:0] r_grant;
  logic [63:0]        r_rd_data;
  logic [6:0]         r_dev;
  logic [7:0]         r_mem;
  logic [63:0]        r_data;
  logic [3:0]         r_size;
  logic               r_rw;

  logic [c_iw-1:0]    w_pick;
  logic [c_iw-1:0]    w_pick_hi;
  logic               w_any;
  logic               w_hit_hi;
  logic [NUM_REQ-1:0] w_onehot;
  logic [6:0]         w_dev;
  logic [7:0]         w_mem;
  logic [63:0]        w_data;
  logic [3:0]         w_size;
  logic               w_rw;
  logic               w_stop_ok;
  logic               w_timeout;
  logic               w_m_rst;
  logic [NUM_REQ-1:0] w_done;

  // The master's stop is only trusted once the guard window has elapsed,
  // since it still reflects the previous transfer right after start.
  assign w_stop_ok = m_stop && (r_cnt >= c_guard);

  // Round-robin pick: lowest pending index at or above the pointer, else lowest overall
  always_comb begin
    w_pick    = '0;
    w_pick_hi = '0;
    w_any     = 1'b0;
    w_hit_hi  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_any  = 1'b1;
        w_pick = c_iw'(i);
        if (c_iw'(i) >= r_ptr) begin
          w_hit_hi  = 1'b1;
          w_pick_hi = c_iw'(i);
        end
      end
    end
    if (w_hit_hi) begin
      w_pick = w_pick_hi;
    end
  end

  // Route the winner's transaction fields and build its one-hot grant
  always_comb begin
    w_onehot = '0;
    w_dev    = '0;
    w_mem    = '0;
    w_data   = '0;
    w_size   = '0;
    w_rw     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == c_iw'(i)) begin
        w_onehot[i] = 1'b1;
        w_dev       = req_dev_addr[7*i +: 7];
        w_mem       = req_mem_addr[8*i +: 8];
        w_data      = req_data[64*i +: 64];
        w_size      = req_size[4*i +: 4];
        w_rw        = req_rw[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:  if (w_any) w_next = c_st_load;
      c_st_load:  w_next = c_st_start;
      c_st_start: w_next = c_st_busy;
      c_st_busy:  if (w_stop_ok || w_timeout) w_next = c_st_done;
      c_st_done:  w_next = c_st_idle;
      default:    w_next = c_st_idle;
    endcase
  end

  // Outputs decoded from state: master held in reset except START/BUSY, done during DONE
  always_comb begin
    w_m_rst = 1'b1;
    w_done  = '0;
    case (r_state)
      c_st_start, c_st_busy: w_m_rst = 1'b0;
      c_st_done:             w_done  = r_grant;
      default:               ;
    endcase
  end

  // Datapath: latch winner fields, run the BUSY counter, capture read data, advance pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant   <= '0;
      r_win     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_rd_data <= '0;
      r_dev     <= '0;
      r_mem     <= '0;
      r_data    <= '0;
      r_size    <= '0;
      r_rw      <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_any) begin
            r_grant <= w_onehot;
            r_win   <= w_pick;
            r_dev   <= w_dev;
            r_mem   <= w_mem;
            r_data  <= w_data;
            r_size  <= w_size;
            r_rw    <= w_rw;
          end
        end
        c_st_start: r_cnt <= '0;
        c_st_busy: begin
          // Saturate so a hung master cannot wrap back into the guard window
          if (r_cnt != c_cnt_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_stop_ok && r_rw) begin
            r_rd_data <= m_rd_data;
          end
        end
        c_st_done: begin
          r_grant <= '0;
          r_ptr   <= (r_win == c_iw'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [c_cw-1:0] c_timeout_last = c_cw'(TIMEOUT_CYCLES - 1);
  logic r_err;

  assign w_timeout = (r_cnt >= c_timeout_last) && !w_stop_ok;

  // Sticky flag recording that a transfer was abandoned on timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((r_state == c_st_busy) && w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  assign grant      = r_grant;
  assign done       = w_done;
  assign rd_data    = r_rd_data;
  assign m_rst      = w_m_rst;
  assign m_dev_addr = r_dev;
  assign m_mem_addr = r_mem;
  assign m_data     = r_data;
  assign m_size     = r_size;
  assign m_rw       = r_rw;

endmodule
`default_nettype wire

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares the single i2c_master instance between NUM_REQ requesters, e.g. mpu6050_gyro_driver plus a second sensor driver.
- Round-robin arbitration between pending requests.
- Latches the winner's transaction fields and pulses the master's reset to start the transfer.
- Waits for the master's stop indication, then returns read data and a per-requester done pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- GUARD_CYCLES, 16, cycles after transfer start during which m_stop is ignored, because stop is still high from the previous transfer.
- TIMEOUT_CYCLES, 2000000, maximum BUSY cycles before abort (only with I2C_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester request level; held until the matching done pulse
- req_dev_addr  in  7*NUM_REQ  flattened device addresses; requester i uses bits [7i+6:7i]
- req_mem_addr  in  8*NUM_REQ  flattened register addresses
- req_data  in  64*NUM_REQ  flattened write data
- req_size  in  4*NUM_REQ  flattened byte counts
- req_rw  in  NUM_REQ  1 = read, 0 = write
- grant  out  NUM_REQ  one-hot owner of the bus, 0 when idle
- done  out  NUM_REQ  one-cycle one-hot completion pulse
- rd_data  out  64  read data of the last completed transfer
- err  out  1  sticky timeout flag; cleared by reset only
- m_rst  out  1  start pulse to i2c_master (its reset input)
- m_dev_addr  out  7  to master
- m_mem_addr  out  8  to master
- m_data  out  64  to master
- m_size  out  4  to master
- m_rw  out  1  to master
- m_stop  in  1  master stop/idle indication
- m_rd_data  in  64  master read data

Behaviour:
- Reset values:
  - grant, done, rd_data, err, m_* outputs all 0, except m_rst = 1, which holds the master idle.
  - State is IDLE and the round-robin pointer is 0.
- IDLE:
  - m_rst = 1.
  - If any req is high, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch that requester's fields into m_*, set grant one-hot, go to LOAD.
  - With no request, stay in IDLE.
- LOAD (1 cycle): m_rst = 1 with the new fields stable. Go to START.
- START: m_rst = 0, clear the cycle counter, go to BUSY.
- BUSY:
  - Counter increments every cycle.
  - m_stop is ignored while counter < GUARD_CYCLES.
  - Afterwards, m_stop = 1 ends the transfer: latch rd_data <= m_rd_data if m_rw = 1 (rd_data unchanged on writes), then go to DONE.
- DONE (1 cycle):
  - done = grant.
  - m_rst = 1.
  - Pointer <= winner index + 1 modulo NUM_REQ.
  - grant clears on the next cycle; go to IDLE.
- Latency:
  - First possible m_rst falling edge is 2 cycles after req is sampled in IDLE.
  - done is at least GUARD_CYCLES + 3 cycles after req.
- m_* fields are frozen from LOAD until IDLE. Requester inputs changing mid-transfer have no effect.
- A requester dropping req mid-transfer does not abort; done still pulses.
- Simultaneous requests: round-robin order. After requester i completes, requester i+1 has priority, so no starvation.
- The same requester re-raising req in the cycle after done is allowed. It wins only if no other request is pending past the pointer.
- Asynchronous reset mid-transfer returns everything to reset values immediately; no done pulse is produced.

Optional Feature:
I2C_ARB_TIMEOUT_EN
- Defined:
  - If the BUSY counter reaches TIMEOUT_CYCLES with no accepted m_stop, set err = 1 (sticky), leave rd_data unchanged, and go to DONE.
  - done still pulses so the requester is released; arbitration continues.
- Undefined: BUSY waits indefinitely, err is tied to 0, and TIMEOUT_CYCLES is unused.

Test Plan:
- Single read: req = 01, req_rw[0] = 1, size 2; model stop at cycle 40 with m_rd_data = 64'h1234 -> grant = 01, one m_rst low window, done = 01 once, rd_data = 64'h1234.
- Simultaneous: req = 11 from reset -> requester 0 served first, then requester 1; grant never 11; two done pulses in order 01, 10.
- Fairness: requester 0 re-requests immediately after each done while requester 1 stays pending -> grants alternate 01, 10, 01.
- Guard window: m_stop held high through START and the first 15 BUSY cycles, then low, then high at cycle 30 -> completion at 30, not earlier.
- Reset mid-BUSY: assert reset at BUSY cycle 10 -> grant = 0 and m_rst = 1 at once; no done; normal transfer after release.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 100, m_stop stuck low -> done at BUSY cycle 100, err = 1 and stays 1, next request still served.
